// File: rtl/ads42_spi_master.sv
// ADS42 configuration-port serial master: shifts a 1..16 bit frame out on SDATA
// MSB first and returns the last min(8,N) SDOUT bits as a readback byte.
module ads42_spi_master #(
  parameter int unsigned CLK_DIV  = 5,
  parameter int unsigned CS_SETUP = 4,
  parameter int unsigned CS_HOLD  = 4
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic [15:0] i_dat_in,
  input  logic        i_opt_start,
  input  logic [7:0]  i_opt_cnt,
  output logic [7:0]  o_dat_out,
  output logic        o_dat_vaild,
  output logic        o_spi_done,
  output logic        o_busy,
  output logic        o_spi_sen,
  output logic        o_spi_sclk,
  output logic        o_spi_sdata,
  input  logic        i_spi_sdout
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);

  state_e      state_q, state_d;
  logic        start_q;
  logic [7:0]  div_q, div_d;
  logic [4:0]  bit_q, bit_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] frame_q, frame_d;
  logic [7:0]  rdbk_q, rdbk_d;
  logic [7:0]  dat_out_q, dat_out_d;
  logic        vaild_q, vaild_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        sen_q, sen_d;
  logic        sclk_q, sclk_d;
  logic        sdata_q, sdata_d;

  logic        start_edge;
  logic [4:0]  eff_cnt;
  logic [7:0]  div_inc;
  logic [4:0]  bit_nxt;

  // Zero and anything above 16 both mean a full 16-bit frame.
  assign eff_cnt    = (i_opt_cnt == 8'd0 || i_opt_cnt > 8'd16) ? 5'd16 : i_opt_cnt[4:0];
  assign start_edge = i_opt_start & ~start_q;
  assign div_inc    = div_q + 8'd1;
  assign bit_nxt    = bit_q + 5'd1;

  // NOTE: every variable driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    rdbk_d    = rdbk_q;
    dat_out_d = dat_out_q;
    vaild_d   = 1'b0;
    done_d    = 1'b0;
    busy_d    = busy_q;
    sen_d     = sen_q;
    sclk_d    = sclk_q;
    sdata_d   = sdata_q;

    unique case (state_q)
      IDLE: begin
        sen_d   = 1'b1;
        sclk_d  = 1'b0;
        sdata_d = 1'b0;
        busy_d  = 1'b0;
        if (start_edge) begin
          state_d = SETUP;
          frame_d = i_dat_in;
          cnt_d   = eff_cnt;
          bit_d   = 5'd0;
          div_d   = 8'd0;
          rdbk_d  = 8'd0;
          sen_d   = 1'b0;
          sdata_d = i_dat_in[15];
          busy_d  = 1'b1;
        end
      end

      SETUP: begin
        if (div_q == SETUP_LAST) begin
          state_d = SHIFT;
          div_d   = 8'd0;
          sclk_d  = 1'b1;
        end else begin
          div_d = div_inc;
        end
      end

      SHIFT: begin
        if (div_q != DIV_LAST) begin
          div_d = div_inc;
        end else begin
          div_d = 8'd0;
          if (sclk_q) begin
            // End of high phase: capture SDOUT, then fall and present the next bit.
            sclk_d  = 1'b0;
            rdbk_d  = {rdbk_q[6:0], i_spi_sdout};
            bit_d   = bit_nxt;
            frame_d = {frame_q[14:0], 1'b0};
            sdata_d = (bit_nxt == cnt_q) ? 1'b0 : frame_q[14];
          end else if (bit_q == cnt_q) begin
            state_d = HOLD;
            sdata_d = 1'b0;
          end else begin
            sclk_d = 1'b1;
          end
        end
      end

      HOLD: begin
        if (div_q == HOLD_LAST) begin
          state_d   = DONE;
          div_d     = 8'd0;
          sen_d     = 1'b1;
          done_d    = 1'b1;
          vaild_d   = 1'b1;
          dat_out_d = rdbk_q;
        end else begin
          div_d = div_inc;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        sen_d   = 1'b1;
        sclk_d  = 1'b0;
        sdata_d = 1'b0;
      end
    endcase
  end

  // NOTE: the datapath registers are reset along with the control state so a
  // frame aborted by reset leaves no stale readback or shift data behind.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      div_q     <= 8'd0;
      bit_q     <= 5'd0;
      cnt_q     <= 5'd0;
      frame_q   <= 16'd0;
      rdbk_q    <= 8'd0;
      dat_out_q <= 8'd0;
      vaild_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      sen_q     <= 1'b1;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      state_q   <= state_d;
      start_q   <= i_opt_start;
      div_q     <= div_d;
      bit_q     <= bit_d;
      cnt_q     <= cnt_d;
      frame_q   <= frame_d;
      rdbk_q    <= rdbk_d;
      dat_out_q <= dat_out_d;
      vaild_q   <= vaild_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      sen_q     <= sen_d;
      sclk_q    <= sclk_d;
      sdata_q   <= sdata_d;
    end
  end

  assign o_dat_out   = dat_out_q;
  assign o_dat_vaild = vaild_q;
  assign o_spi_done  = done_q;
  assign o_busy      = busy_q;
  assign o_spi_sen   = sen_q;
  assign o_spi_sclk  = sclk_q;
  assign o_spi_sdata = sdata_q;

endmodule

// File: tb/tb_ads42_spi_master.sv
// Bench for ads42_spi_master: table of frames plus hand sequences for retrigger,
// mid-frame start, and reset during a frame; expectations held in a scoreboard.
module tb_ads42_spi_master;

  localparam int CLK_DIV  = 5;
  localparam int CS_SETUP = 4;
  localparam int CS_HOLD  = 4;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic [15:0] i_dat_in;
  logic        i_opt_start;
  logic [7:0]  i_opt_cnt;
  logic [7:0]  o_dat_out;
  logic        o_dat_vaild;
  logic        o_spi_done;
  logic        o_busy;
  logic        o_spi_sen;
  logic        o_spi_sclk;
  logic        o_spi_sdata;
  logic        i_spi_sdout;

  ads42_spi_master #(
    .CLK_DIV (CLK_DIV),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD)
  ) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .i_dat_in   (i_dat_in),
    .i_opt_start(i_opt_start),
    .i_opt_cnt  (i_opt_cnt),
    .o_dat_out  (o_dat_out),
    .o_dat_vaild(o_dat_vaild),
    .o_spi_done (o_spi_done),
    .o_busy     (o_busy),
    .o_spi_sen  (o_spi_sen),
    .o_spi_sclk (o_spi_sclk),
    .o_spi_sdata(o_spi_sdata),
    .i_spi_sdout(i_spi_sdout)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ADC model: during the high phase of bit k (1-based) SDOUT returns resp_q[16-k].
  logic [15:0] resp_q = 16'd0;
  logic [4:0]  rise_cnt = 5'd0;
  logic [15:0] cap = 16'd0;
  int          total_rises = 0;
  int          done_cnt = 0;
  logic [3:0]  sd_idx;

  always @(negedge o_spi_sen) begin
    rise_cnt <= 5'd0;
    cap      <= 16'd0;
  end

  always @(posedge o_spi_sclk) begin
    rise_cnt    <= rise_cnt + 5'd1;
    total_rises <= total_rises + 1;
    cap         <= {cap[14:0], o_spi_sdata};
  end

  always @(negedge sys_clk) begin
    if (o_spi_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  assign sd_idx      = 4'(5'd16 - rise_cnt);
  assign i_spi_sdout = (rise_cnt != 5'd0 && rise_cnt <= 5'd16) ? resp_q[sd_idx] : 1'b0;

  typedef struct {
    logic [15:0] dat;
    logic [7:0]  cnt;
    logic [15:0] resp;
    int          exp_n;
    logic [7:0]  exp_out;
  } vec_t;

  typedef struct {
    int          latency;
    int          n;
    logic [15:0] bits;
    logic        first_bit;
    logic [7:0]  dat_out;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];

  function automatic exp_t predict(input logic [15:0] dat, input int n, input logic [7:0] out);
    exp_t e;
    e.latency   = 1 + CS_SETUP + 2 * CLK_DIV * n + CS_HOLD;
    e.n         = n;
    e.bits      = dat >> (16 - n);
    e.first_bit = dat[15];
    e.dat_out   = out;
    return e;
  endfunction

  // Called at the negedge where start was just raised; the next posedge launches.
  task automatic wait_done(input string tag);
    exp_t e;
    int   lat;
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    @(posedge sys_clk);
    lat = 0;
    do begin
      @(negedge sys_clk);
      lat++;
      if (lat == 1) begin
        check({tag, " sen low after launch"}, 32'(o_spi_sen), 32'd0);
        check({tag, " busy after launch"}, 32'(o_busy), 32'd1);
        check({tag, " sclk idle in setup"}, 32'(o_spi_sclk), 32'd0);
        check({tag, " first sdata bit"}, 32'(o_spi_sdata), 32'(e.first_bit));
      end
    end while (o_spi_done !== 1'b1 && lat < 400);
    check({tag, " latency"}, 32'(lat), 32'(e.latency));
    check({tag, " valid in done cycle"}, 32'(o_dat_vaild), 32'd1);
    check({tag, " readback"}, 32'(o_dat_out), 32'(e.dat_out));
    check({tag, " sen high in done cycle"}, 32'(o_spi_sen), 32'd1);
    check({tag, " busy in done cycle"}, 32'(o_busy), 32'd1);
    check({tag, " sclk rising edges"}, 32'(rise_cnt), 32'(e.n));
    check({tag, " sdata bits"}, 32'(cap), 32'(e.bits));
    @(negedge sys_clk);
    check({tag, " done is one cycle"}, 32'(o_spi_done), 32'd0);
    check({tag, " valid is one cycle"}, 32'(o_dat_vaild), 32'd0);
    check({tag, " busy drops"}, 32'(o_busy), 32'd0);
    check({tag, " sen gap"}, 32'(o_spi_sen), 32'd1);
    check({tag, " readback held"}, 32'(o_dat_out), 32'(e.dat_out));
  endtask

  task automatic launch(input logic [15:0] dat, input logic [7:0] cnt, input logic [15:0] resp,
                        input int exp_n, input logic [7:0] exp_out);
    i_opt_start = 1'b0;
    @(negedge sys_clk);
    i_dat_in    = dat;
    i_opt_cnt   = cnt;
    resp_q      = resp;
    i_opt_start = 1'b1;
    sb.push_back(predict(dat, exp_n, exp_out));
  endtask

  initial begin
    int done_snap;
    int rise_snap;
    int guard;

    vecs[0] = '{16'h8680, 8'd16,  16'h00A5, 16, 8'hA5};
    vecs[1] = '{16'h1234, 8'd0,   16'h3C5A, 16, 8'h5A};
    vecs[2] = '{16'hABCD, 8'd200, 16'h1281, 16, 8'h81};
    vecs[3] = '{16'hF000, 8'd4,   16'hB000, 4,  8'h0B};
    vecs[4] = '{16'h8001, 8'd1,   16'h8000, 1,  8'h01};
    vecs[5] = '{16'h5555, 8'd8,   16'hC300, 8,  8'hC3};
    vecs[6] = '{16'h7FFF, 8'd12,  16'h9A50, 12, 8'hA5};
    vecs[7] = '{16'h0000, 8'd17,  16'hFFFF, 16, 8'hFF};

    rst         = 1'b1;
    i_opt_start = 1'b0;
    i_dat_in    = 16'd0;
    i_opt_cnt   = 8'd0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("reset sen", 32'(o_spi_sen), 32'd1);
    check("reset sclk", 32'(o_spi_sclk), 32'd0);
    check("reset sdata", 32'(o_spi_sdata), 32'd0);
    check("reset done", 32'(o_spi_done), 32'd0);
    check("reset valid", 32'(o_dat_vaild), 32'd0);
    check("reset busy", 32'(o_busy), 32'd0);
    check("reset dat_out", 32'(o_dat_out), 32'd0);
    rst = 1'b0;
    rise_snap = total_rises;
    repeat (100) @(negedge sys_clk);
    check("idle no sclk edges", 32'(total_rises - rise_snap), 32'd0);
    check("idle busy", 32'(o_busy), 32'd0);

    for (int i = 0; i < 8; i++) begin
      launch(vecs[i].dat, vecs[i].cnt, vecs[i].resp, vecs[i].exp_n, vecs[i].exp_out);
      wait_done($sformatf("vec%0d", i));
    end

    // Start held high after done must not retrigger.
    done_snap = done_cnt;
    rise_snap = total_rises;
    repeat (300) @(negedge sys_clk);
    check("held start no retrigger done", 32'(done_cnt), 32'(done_snap));
    check("held start no sclk", 32'(total_rises), 32'(rise_snap));
    check("held start idle", 32'(o_busy), 32'd0);

    // A fresh start edge during a frame is ignored.
    done_snap = done_cnt;
    launch(16'hC33C, 8'd16, 16'h005A, 16, 8'h5A);
    fork
      wait_done("busy_edge");
      begin
        repeat (40) @(negedge sys_clk);
        i_opt_start = 1'b0;
        @(negedge sys_clk);
        i_opt_start = 1'b1;
      end
    join
    check("busy_edge single done", 32'(done_cnt - done_snap), 32'd1);

    // Reset at the 7th SCLK rising edge, start held high through release.
    launch(16'h8680, 8'd16, 16'h00A5, 16, 8'hA5);
    sb.delete();
    guard = 0;
    while (rise_cnt != 5'd7 && guard < 300) begin
      @(negedge sys_clk);
      guard++;
    end
    check("reach sclk edge 7", 32'(rise_cnt), 32'd7);
    done_snap = done_cnt;
    rst = 1'b1;
    @(negedge sys_clk);
    check("midreset sen", 32'(o_spi_sen), 32'd1);
    check("midreset sclk", 32'(o_spi_sclk), 32'd0);
    check("midreset busy", 32'(o_busy), 32'd0);
    check("midreset sdata", 32'(o_spi_sdata), 32'd0);
    check("midreset dat_out", 32'(o_dat_out), 32'd0);
    @(negedge sys_clk);
    check("midreset no done", 32'(done_cnt), 32'(done_snap));
    check("midreset no valid", 32'(o_dat_vaild), 32'd0);
    resp_q = 16'h0096;
    sb.push_back(predict(16'h8680, 16, 8'h96));
    rst = 1'b0;
    wait_done("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
